// File: rtl/ddr_pkg.sv
// Shared types and constants for the dance game pattern path.
// The score tracker relies on the same pattern and timer widths.
package ddr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    SHOW = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int PAT_W   = 4;
  localparam int TIMER_W = 20;
  localparam int COUNT_W = 6;

  // Galois LFSR, right shift. A non-zero state never maps to zero.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
  endfunction

  // An all-zero arrow pattern cannot be hit, so it becomes a single arrow.
  function automatic logic [PAT_W-1:0] nz_nibble(input logic [PAT_W-1:0] n);
    return (n == '0) ? PAT_W'(1) : n;
  endfunction

endpackage

// File: rtl/dance_pattern_sequencer_if.sv
// Pattern bus from the sequencer (producer) to the score tracker (consumer).
interface dance_pattern_sequencer_if;
  import ddr_pkg::*;

  logic [PAT_W-1:0]   pattern_a;
  logic [PAT_W-1:0]   pattern_b;
  logic               pattern_valid;
  logic [TIMER_W-1:0] pattern_timer;

  modport master (
    output pattern_a,
    output pattern_b,
    output pattern_valid,
    output pattern_timer
  );

  modport slave (
    input pattern_a,
    input pattern_b,
    input pattern_valid,
    input pattern_timer
  );
endinterface

// File: rtl/pattern_lfsr.sv
// 16-bit Galois LFSR with synchronous seed load; load takes priority over step.
module pattern_lfsr
  import ddr_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] value
);

  logic [15:0] value_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      value_reg <= SEED;
    end else if (load) begin
      value_reg <= seed;
    end else if (step) begin
      value_reg <= lfsr_next(value_reg);
    end
  end

  assign value = value_reg;

endmodule

// File: rtl/dance_pattern_sequencer.sv
// Produces timed arrow patterns for a fixed-length game: blank gap, then a
// hit window per pattern, until NUM_PATTERNS windows have completed.
module dance_pattern_sequencer
  import ddr_pkg::*;
#(
  parameter int          TICK_DIV     = 50,
  parameter int          WINDOW_TICKS = 500000,
  parameter int          GAP_TICKS    = 250000,
  parameter int          NUM_PATTERNS = 32,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    game_active,
  input  logic                    mirror_mode,
  dance_pattern_sequencer_if.master pat,
  output logic [COUNT_W-1:0]      pattern_count,
  output logic                    game_over
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  state_t             state_reg, state_next;
  logic [PRE_W-1:0]   presc_reg, presc_next;
  logic [GAP_W-1:0]   gap_reg, gap_next;
  logic [TIMER_W-1:0] timer_reg, timer_next;
  logic [COUNT_W-1:0] count_reg, count_next;
  logic [PAT_W-1:0]   pat_a_reg, pat_a_next;
  logic [PAT_W-1:0]   pat_b_reg, pat_b_next;
  logic               valid_reg, valid_next;

  logic               tick;
  logic               lfsr_load;
  logic               lfsr_step;
  logic [15:0]        lfsr_value;
  logic [PAT_W-1:0]   new_a;
  logic [PAT_W-1:0]   new_b;
  logic [COUNT_W-1:0] count_inc;

  pattern_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clock (clock),
    .reset (reset),
    .load  (lfsr_load),
    .seed  (SEED),
    .step  (lfsr_step),
    .value (lfsr_value)
  );

  assign tick      = (presc_reg == PRE_W'(TICK_DIV - 1));
  assign new_a     = nz_nibble(lfsr_value[3:0]);
  assign new_b     = mirror_mode ? new_a : nz_nibble(lfsr_value[7:4]);
  assign count_inc = count_reg + COUNT_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      presc_reg <= '0;
      gap_reg   <= '0;
      timer_reg <= '0;
      count_reg <= '0;
      pat_a_reg <= '0;
      pat_b_reg <= '0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      presc_reg <= presc_next;
      gap_reg   <= gap_next;
      timer_reg <= timer_next;
      count_reg <= count_next;
      pat_a_reg <= pat_a_next;
      pat_b_reg <= pat_b_next;
      valid_reg <= valid_next;
    end
  end

  // Every state change also zeroes the prescaler so window/gap lengths are exact.
  always_comb begin
    state_next = state_reg;
    presc_next = tick ? '0 : presc_reg + PRE_W'(1);
    gap_next   = gap_reg;
    timer_next = timer_reg;
    count_next = count_reg;
    pat_a_next = pat_a_reg;
    pat_b_next = pat_b_reg;
    valid_next = valid_reg;
    lfsr_load  = 1'b0;
    lfsr_step  = 1'b0;

    unique case (state_reg)
      IDLE: begin
        presc_next = '0;
        if (game_active) begin
          state_next = GAP;
          lfsr_load  = 1'b1;
          count_next = '0;
          gap_next   = '0;
        end
      end
      GAP: begin
        if (!game_active) begin
          state_next = IDLE;
          presc_next = '0;
        end else if (tick) begin
          if (gap_reg == GAP_W'(GAP_TICKS - 1)) begin
            state_next = SHOW;
            presc_next = '0;
            pat_a_next = new_a;
            pat_b_next = new_b;
            lfsr_step  = 1'b1;
            valid_next = 1'b1;
            timer_next = '0;
          end else begin
            gap_next = gap_reg + GAP_W'(1);
          end
        end
      end
      SHOW: begin
        if (!game_active) begin
          // Aborted window is dropped without being counted.
          state_next = IDLE;
          presc_next = '0;
          valid_next = 1'b0;
          timer_next = '0;
          pat_a_next = '0;
          pat_b_next = '0;
        end else if (tick) begin
          if (timer_reg == TIMER_W'(WINDOW_TICKS - 1)) begin
            count_next = count_inc;
            presc_next = '0;
            gap_next   = '0;
            valid_next = 1'b0;
            timer_next = '0;
            pat_a_next = '0;
            pat_b_next = '0;
            state_next = (count_inc == COUNT_W'(NUM_PATTERNS)) ? DONE : GAP;
          end else begin
            timer_next = timer_reg + TIMER_W'(1);
          end
        end
      end
      DONE: begin
        presc_next = '0;
        if (!game_active) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign pat.pattern_a     = pat_a_reg;
  assign pat.pattern_b     = pat_b_reg;
  assign pat.pattern_valid = valid_reg;
  assign pat.pattern_timer = timer_reg;
  assign pattern_count     = count_reg;
  assign game_over         = (state_reg == DONE);

endmodule

// File: tb/tb_dance_pattern_sequencer.sv
// Directed bench: small timing parameters, hand-derived LFSR patterns
// (ACE1 -> E270 -> 7138), abort, reset and DONE-hold scenarios.
module tb_dance_pattern_sequencer;
  import ddr_pkg::*;

  logic                clock;
  logic                reset;
  logic                game_active;
  logic                mirror_mode;
  logic [COUNT_W-1:0]  pattern_count;
  logic                game_over;

  int tests_run;
  int tests_failed;

  dance_pattern_sequencer_if pif ();

  dance_pattern_sequencer #(
    .TICK_DIV     (2),
    .WINDOW_TICKS (4),
    .GAP_TICKS    (2),
    .NUM_PATTERNS (3),
    .SEED         (16'hACE1)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .game_active   (game_active),
    .mirror_mode   (mirror_mode),
    .pat           (pif),
    .pattern_count (pattern_count),
    .game_over     (game_over)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Waits (bounded) for a window, then checks its length, timer and patterns.
  task automatic run_window(input string tag, input logic [3:0] exp_a,
                            input logic [3:0] exp_b, output int latency);
    int n;
    n = 0;
    while (!pif.pattern_valid && n < 60) begin
      cyc();
      n++;
    end
    latency = n;
    if (!pif.pattern_valid) begin
      check({tag, "_wait_valid"}, 32'(pif.pattern_valid), 32'd1);
      return;
    end
    for (int i = 0; i < 8; i++) begin
      check({tag, "_valid"}, 32'(pif.pattern_valid), 32'd1);
      check({tag, "_timer"}, 32'(pif.pattern_timer), 32'(i / 2));
      if (i == 0) begin
        check({tag, "_a"}, 32'(pif.pattern_a), 32'(exp_a));
        check({tag, "_b"}, 32'(pif.pattern_b), 32'(exp_b));
      end
      cyc();
    end
    check({tag, "_closed"}, 32'(pif.pattern_valid), 32'd0);
    check({tag, "_a_clr"}, 32'(pif.pattern_a), 32'd0);
    $display("[TB] %s: a=%0h b=%0h latency=%0d count=%0d", tag, exp_a, exp_b, latency,
             pattern_count);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int n;
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    game_active  = 1'b0;
    mirror_mode  = 1'b0;
    repeat (3) cyc();

    check("rst_valid", 32'(pif.pattern_valid), 32'd0);
    check("rst_a", 32'(pif.pattern_a), 32'd0);
    check("rst_timer", 32'(pif.pattern_timer), 32'd0);
    check("rst_count", 32'(pattern_count), 32'd0);
    check("rst_over", 32'(game_over), 32'd0);
    reset = 1'b0;
    cyc();
    $display("[TB] reset released");

    // Game 1: independent patterns, full run to DONE.
    game_active = 1'b1;
    run_window("g1w1", 4'h1, 4'hE, lat);
    check("g1w1_latency", 32'(lat), 32'd5);
    check("g1w1_count", 32'(pattern_count), 32'd1);
    run_window("g1w2", 4'h1, 4'h7, lat);
    run_window("g1w3", 4'h8, 4'h3, lat);
    check("g1_over", 32'(game_over), 32'd1);
    check("g1_count", 32'(pattern_count), 32'd3);
    repeat (20) cyc();
    check("g1_over_hold", 32'(game_over), 32'd1);
    check("g1_hold_valid", 32'(pif.pattern_valid), 32'd0);
    check("g1_hold_count", 32'(pattern_count), 32'd3);
    game_active = 1'b0;
    cyc();
    check("g1_over_drop", 32'(game_over), 32'd0);
    $display("[TB] game 1 acknowledged");

    // Game 2: restart replays the sequence, then abort mid window 2.
    game_active = 1'b1;
    run_window("g2w1", 4'h1, 4'hE, lat);
    check("g2w1_latency", 32'(lat), 32'd5);
    n = 0;
    while (!(pif.pattern_valid && pif.pattern_timer == 20'd2) && n < 60) begin
      cyc();
      n++;
    end
    check("g2_reach_t2", 32'(pif.pattern_timer), 32'd2);
    game_active = 1'b0;
    cyc();
    check("abort_valid", 32'(pif.pattern_valid), 32'd0);
    check("abort_timer", 32'(pif.pattern_timer), 32'd0);
    check("abort_a", 32'(pif.pattern_a), 32'd0);
    check("abort_count", 32'(pattern_count), 32'd1);
    check("abort_over", 32'(game_over), 32'd0);
    repeat (10) cyc();
    check("abort_over_later", 32'(game_over), 32'd0);
    check("abort_state", 32'(dut.state_reg), 32'(IDLE));
    $display("[TB] game 2 aborted in window 2");

    // Game 3: mirror mode.
    mirror_mode = 1'b1;
    game_active = 1'b1;
    run_window("g3w1", 4'h1, 4'h1, lat);
    run_window("g3w2", 4'h1, 4'h1, lat);
    run_window("g3w3", 4'h8, 4'h8, lat);
    check("g3_over", 32'(game_over), 32'd1);
    game_active = 1'b0;
    mirror_mode = 1'b0;
    cyc();
    $display("[TB] game 3 mirror done");

    // Game 4: reset in the middle of a window.
    game_active = 1'b1;
    n = 0;
    while (!pif.pattern_valid && n < 60) begin
      cyc();
      n++;
    end
    repeat (3) cyc();
    check("pre_rst_valid", 32'(pif.pattern_valid), 32'd1);
    reset = 1'b1;
    cyc();
    check("mrst_valid", 32'(pif.pattern_valid), 32'd0);
    check("mrst_a", 32'(pif.pattern_a), 32'd0);
    check("mrst_b", 32'(pif.pattern_b), 32'd0);
    check("mrst_timer", 32'(pif.pattern_timer), 32'd0);
    check("mrst_count", 32'(pattern_count), 32'd0);
    check("mrst_over", 32'(game_over), 32'd0);
    check("mrst_state", 32'(dut.state_reg), 32'(IDLE));
    reset = 1'b0;
    run_window("g4w1", 4'h1, 4'hE, lat);
    check("g4w1_latency", 32'(lat), 32'd5);
    game_active = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
